point_update_sequencer: RTL and testbench

Sequences one shared `update_point` instance across every mass point of the squishy car once per physics step. Holds position/velocity state for `NUM_POINTS` points in an internal register file. On each step, issues one `update_point` transaction per point in index order and writes the results back. A watchdog keeps a hung transaction from stalling the frame. Sits between the frame-tick logic and the `update_point`/`collisions` datapath. The renderer and the loader access point state through a host port.

---
 rtl/point_update_sequencer_pkg.sv | 33 +++
 rtl/point_regfile.sv | 72 +++++++
 rtl/point_update_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_point_update_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/point_update_sequencer_pkg.sv
// rtl/point_update_sequencer_pkg.sv - shared types and default widths for the point update sequencer
package point_update_sequencer_pkg;

  localparam int DEF_NUM_POINTS     = 8;
  localparam int DEF_POSITION_SIZE  = 8;
  localparam int DEF_VELOCITY_SIZE  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int TIMEOUT_COUNT_W    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_NEXT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    NEXT  = ST_NEXT
  } seq_state_t;

  typedef struct packed {
    logic [DEF_POSITION_SIZE-1:0] pos_x;
    logic [DEF_POSITION_SIZE-1:0] pos_y;
    logic [DEF_VELOCITY_SIZE-1:0] vel_x;
    logic [DEF_VELOCITY_SIZE-1:0] vel_y;
  } point_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/point_regfile.sv
// rtl/point_regfile.sv - point state storage: one sync write, one registered read, one async operand read
module point_regfile
  import point_update_sequencer_pkg::*;
#(
  parameter int NUM_POINTS    = DEF_NUM_POINTS,
  parameter int POSITION_SIZE = DEF_POSITION_SIZE,
  parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
  localparam int IDXW         = idx_width(NUM_POINTS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [IDXW-1:0]          wr_idx_i,
  input  logic [POSITION_SIZE-1:0] wr_pos_x_i,
  input  logic [POSITION_SIZE-1:0] wr_pos_y_i,
  input  logic [VELOCITY_SIZE-1:0] wr_vel_x_i,
  input  logic [VELOCITY_SIZE-1:0] wr_vel_y_i,
  input  logic [IDXW-1:0]          rd_idx_i,
  output logic [POSITION_SIZE-1:0] rd_pos_x_o,
  output logic [POSITION_SIZE-1:0] rd_pos_y_o,
  output logic [VELOCITY_SIZE-1:0] rd_vel_x_o,
  output logic [VELOCITY_SIZE-1:0] rd_vel_y_o,
  input  logic [IDXW-1:0]          op_idx_i,
  output logic [POSITION_SIZE-1:0] op_pos_x_o,
  output logic [POSITION_SIZE-1:0] op_pos_y_o,
  output logic [VELOCITY_SIZE-1:0] op_vel_x_o,
  output logic [VELOCITY_SIZE-1:0] op_vel_y_o
);

  localparam logic [IDXW:0] NUM_W = (IDXW+1)'(NUM_POINTS);

  logic [POSITION_SIZE-1:0] pos_x_q [NUM_POINTS];
  logic [POSITION_SIZE-1:0] pos_y_q [NUM_POINTS];
  logic [VELOCITY_SIZE-1:0] vel_x_q [NUM_POINTS];
  logic [VELOCITY_SIZE-1:0] vel_y_q [NUM_POINTS];

  logic rd_ok;
  assign rd_ok = ({1'b0, rd_idx_i} < NUM_W);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
        vel_x_q[i] <= '0;
        vel_y_q[i] <= '0;
      end
      rd_pos_x_o <= '0;
      rd_pos_y_o <= '0;
      rd_vel_x_o <= '0;
      rd_vel_y_o <= '0;
    end else begin
      if (wr_en_i) begin
        pos_x_q[wr_idx_i] <= wr_pos_x_i;
        pos_y_q[wr_idx_i] <= wr_pos_y_i;
        vel_x_q[wr_idx_i] <= wr_vel_x_i;
        vel_y_q[wr_idx_i] <= wr_vel_y_i;
      end
      // Read returns the stored value before any same-edge write.
      rd_pos_x_o <= rd_ok ? pos_x_q[rd_idx_i] : '0;
      rd_pos_y_o <= rd_ok ? pos_y_q[rd_idx_i] : '0;
      rd_vel_x_o <= rd_ok ? vel_x_q[rd_idx_i] : '0;
      rd_vel_y_o <= rd_ok ? vel_y_q[rd_idx_i] : '0;
    end
  end

  assign op_pos_x_o = pos_x_q[op_idx_i];
  assign op_pos_y_o = pos_y_q[op_idx_i];
  assign op_vel_x_o = vel_x_q[op_idx_i];
  assign op_vel_y_o = vel_y_q[op_idx_i];

endmodule

// File: rtl/point_update_sequencer.sv
// rtl/point_update_sequencer.sv - steps one shared update_point unit across all mass points with a watchdog
module point_update_sequencer
  import point_update_sequencer_pkg::*;
#(
  parameter int NUM_POINTS     = DEF_NUM_POINTS,
  parameter int POSITION_SIZE  = DEF_POSITION_SIZE,
  parameter int VELOCITY_SIZE  = DEF_VELOCITY_SIZE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDXW          = idx_width(NUM_POINTS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       step_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [TIMEOUT_COUNT_W-1:0] timeout_count_out,
  input  logic                       wr_en_in,
  input  logic [IDXW-1:0]            wr_idx_in,
  input  logic [POSITION_SIZE-1:0]   wr_pos_x_in,
  input  logic [POSITION_SIZE-1:0]   wr_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0]   wr_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0]   wr_vel_y_in,
  input  logic [IDXW-1:0]            rd_idx_in,
  output logic [POSITION_SIZE-1:0]   rd_pos_x_out,
  output logic [POSITION_SIZE-1:0]   rd_pos_y_out,
  output logic [VELOCITY_SIZE-1:0]   rd_vel_x_out,
  output logic [VELOCITY_SIZE-1:0]   rd_vel_y_out,
  output logic                       up_begin_out,
  output logic [POSITION_SIZE-1:0]   up_pos_x_out,
  output logic [POSITION_SIZE-1:0]   up_pos_y_out,
  output logic [VELOCITY_SIZE-1:0]   up_vel_x_out,
  output logic [VELOCITY_SIZE-1:0]   up_vel_y_out,
  input  logic                       up_result_in,
  input  logic [POSITION_SIZE-1:0]   up_new_pos_x_in,
  input  logic [POSITION_SIZE-1:0]   up_new_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0]   up_new_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0]   up_new_vel_y_in
);

  localparam int              WDW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_POINTS - 1);
  localparam logic [IDXW:0]   NUM_W    = (IDXW+1)'(NUM_POINTS);

  seq_state_t                 state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [WDW-1:0]             wd_q, wd_d;
  logic [TIMEOUT_COUNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic [POSITION_SIZE-1:0]   op_px_q, op_px_d, op_py_q, op_py_d;
  logic [VELOCITY_SIZE-1:0]   op_vx_q, op_vx_d, op_vy_q, op_vy_d;

  logic                     host_wr, res_wr, rf_we, bypass;
  logic [IDXW-1:0]          rf_widx, op_idx;
  logic [POSITION_SIZE-1:0] rf_px, rf_py, rf_op_px, rf_op_py, nxt_px, nxt_py;
  logic [VELOCITY_SIZE-1:0] rf_vx, rf_vy, rf_op_vx, rf_op_vy, nxt_vx, nxt_vy;

  // Host writes only land in IDLE, results only in WAIT, so the port is never contended.
  assign host_wr = (state_q == IDLE) && wr_en_in && ({1'b0, wr_idx_in} < NUM_W);
  assign res_wr  = (state_q == WAIT) && up_result_in;
  assign rf_we   = host_wr || res_wr;
  assign rf_widx = res_wr ? idx_q : wr_idx_in;
  assign rf_px   = res_wr ? up_new_pos_x_in : wr_pos_x_in;
  assign rf_py   = res_wr ? up_new_pos_y_in : wr_pos_y_in;
  assign rf_vx   = res_wr ? up_new_vel_x_in : wr_vel_x_in;
  assign rf_vy   = res_wr ? up_new_vel_y_in : wr_vel_y_in;

  // A write coincident with step acceptance must be visible in point 0's operands.
  assign op_idx = (state_q == NEXT) ? idx_q + 1'b1 : '0;
  assign bypass = host_wr && (wr_idx_in == op_idx);
  assign nxt_px = bypass ? wr_pos_x_in : rf_op_px;
  assign nxt_py = bypass ? wr_pos_y_in : rf_op_py;
  assign nxt_vx = bypass ? wr_vel_x_in : rf_op_vx;
  assign nxt_vy = bypass ? wr_vel_y_in : rf_op_vy;

  point_regfile #(
    .NUM_POINTS   (NUM_POINTS),
    .POSITION_SIZE(POSITION_SIZE),
    .VELOCITY_SIZE(VELOCITY_SIZE)
  ) u_regfile (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .wr_en_i   (rf_we),
    .wr_idx_i  (rf_widx),
    .wr_pos_x_i(rf_px),
    .wr_pos_y_i(rf_py),
    .wr_vel_x_i(rf_vx),
    .wr_vel_y_i(rf_vy),
    .rd_idx_i  (rd_idx_in),
    .rd_pos_x_o(rd_pos_x_out),
    .rd_pos_y_o(rd_pos_y_out),
    .rd_vel_x_o(rd_vel_x_out),
    .rd_vel_y_o(rd_vel_y_out),
    .op_idx_i  (op_idx),
    .op_pos_x_o(rf_op_px),
    .op_pos_y_o(rf_op_py),
    .op_vel_x_o(rf_op_vx),
    .op_vel_y_o(rf_op_vy)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    to_cnt_d = to_cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    op_px_d  = op_px_q;
    op_py_d  = op_py_q;
    op_vx_d  = op_vx_q;
    op_vy_d  = op_vy_q;
    case (state_q)
      IDLE: begin
        if (step_in) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          idx_d   = '0;
          op_px_d = nxt_px;
          op_py_d = nxt_py;
          op_vx_d = nxt_vx;
          op_vy_d = nxt_vy;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // A result arriving on the expiry cycle wins over the timeout.
        if (up_result_in) begin
          state_d = NEXT;
        end else if (wd_q == WD_LAST) begin
          state_d = NEXT;
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          op_px_d = nxt_px;
          op_py_d = nxt_py;
          op_vx_d = nxt_vx;
          op_vy_d = nxt_vy;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wd_q     <= '0;
      to_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_px_q  <= '0;
      op_py_q  <= '0;
      op_vx_q  <= '0;
      op_vy_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      to_cnt_q <= to_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      op_px_q  <= op_px_d;
      op_py_q  <= op_py_d;
      op_vx_q  <= op_vx_d;
      op_vy_q  <= op_vy_d;
    end
  end

  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign timeout_count_out = to_cnt_q;
  assign up_begin_out      = (state_q == ISSUE);
  assign up_pos_x_out      = op_px_q;
  assign up_pos_y_out      = op_py_q;
  assign up_vel_x_out      = op_vx_q;
  assign up_vel_y_out      = op_vy_q;

endmodule

// File: tb/tb_point_update_sequencer.sv
// tb/tb_point_update_sequencer.sv - directed self-checking bench for point_update_sequencer
module tb_point_update_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, step, wr_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [7:0]    wpx, wpy, wvx, wvy;
  logic          busy, done, up_begin;
  logic [7:0]    to_cnt, rpx, rpy, rvx, rvy, upx, upy, uvx, uvy;
  logic          up_result = 1'b0;
  logic [7:0]    npx = 8'd0, npy = 8'd0, nvx = 8'd0, nvy = 8'd0;

  point_update_sequencer #(
    .NUM_POINTS(N), .POSITION_SIZE(8), .VELOCITY_SIZE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .step_in(step), .busy_out(busy), .done_out(done),
    .timeout_count_out(to_cnt), .wr_en_in(wr_en), .wr_idx_in(wr_idx),
    .wr_pos_x_in(wpx), .wr_pos_y_in(wpy), .wr_vel_x_in(wvx), .wr_vel_y_in(wvy),
    .rd_idx_in(rd_idx), .rd_pos_x_out(rpx), .rd_pos_y_out(rpy),
    .rd_vel_x_out(rvx), .rd_vel_y_out(rvy), .up_begin_out(up_begin),
    .up_pos_x_out(upx), .up_pos_y_out(upy), .up_vel_x_out(uvx), .up_vel_y_out(uvy),
    .up_result_in(up_result), .up_new_pos_x_in(npx), .up_new_pos_y_in(npy),
    .up_new_vel_x_in(nvx), .up_new_vel_y_in(nvy)
  );

  int tests = 0, fails = 0;

  // update_point stand-in: answers pos+1, vel_x+2, vel_y+3 after lat cycles
  int         model_en = 0, lat = 3, mcnt = 0;
  logic       pend = 1'b0;
  logic [7:0] cpx, cpy, cvx, cvy;
  always @(negedge clk) begin
    up_result = 1'b0;
    if (pend) begin
      mcnt--;
      if (mcnt == 0) begin
        up_result = 1'b1;
        npx = cpx + 8'd1; npy = cpy + 8'd1; nvx = cvx + 8'd2; nvy = cvy + 8'd3;
        pend = 1'b0;
      end
    end
    if (up_begin && model_en != 0) begin
      pend = 1'b1; mcnt = lat;
      cpx = upx; cpy = upy; cvx = uvx; cvy = uvy;
    end
  end

  logic [7:0] exp_px [N], exp_py [N], exp_vx [N], exp_vy [N];
  int         beg_cyc [16];
  logic [7:0] beg_px [16];
  int         nbeg, done_cyc, done_cnt, release_at = -1;

  task automatic watch(input int max_cyc, input bit stop_on_done);
    nbeg = 0; done_cyc = -1; done_cnt = 0;
    for (int n = 0; n < max_cyc; n++) begin
      if (n == release_at) step = 1'b0;
      if (up_begin) begin
        if (nbeg < 16) begin beg_cyc[nbeg] = n; beg_px[nbeg] = upx; end
        nbeg++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
        if (stop_on_done) break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_read(input int i);
    rd_idx = IW'(i);
    @(negedge clk);
  endtask

  task automatic do_write(input int i, input logic [7:0] px, py, vx, vy);
    wr_en = 1'b1; wr_idx = IW'(i); wpx = px; wpy = py; wvx = vx; wvy = vy;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic inc_exp();
    for (int i = 0; i < N; i++) begin
      exp_px[i] += 8'd1; exp_py[i] += 8'd1; exp_vx[i] += 8'd2; exp_vy[i] += 8'd3;
    end
  endtask

  task automatic check_points(input string tag);
    for (int i = 0; i < N; i++) begin
      do_read(i);
      tests++;
      if (rpx !== exp_px[i] || rpy !== exp_py[i] || rvx !== exp_vx[i] || rvy !== exp_vy[i]) begin
        fails++;
        $display("FAIL %s pt%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", tag, i,
                 rpx, rpy, rvx, rvy, exp_px[i], exp_py[i], exp_vx[i], exp_vy[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step = 1'b0; wr_en = 1'b0; wr_idx = '0; rd_idx = IW'(1);
    wpx = '0; wpy = '0; wvx = '0; wvy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || up_begin !== 1'b0 || to_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b done=%b begin=%b to=%0d expected 0/0/0/0", busy, done, up_begin, to_cnt);
    end
    tests++;
    if (upx !== 8'd0 || uvy !== 8'd0 || rpx !== 8'd0 || rvy !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: got up=%0d/%0d rd=%0d/%0d expected 0", upx, uvy, rpx, rvy);
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < N; k++) begin
      exp_px[k] = 8'(10*k); exp_py[k] = 8'(10*k+5); exp_vx[k] = 8'(k); exp_vy[k] = 8'(100+k);
      do_write(k, exp_px[k], exp_py[k], exp_vx[k], exp_vy[k]);
    end
    do_read(2);
    tests++;
    if (rpx !== 8'd20 || rpy !== 8'd25 || rvx !== 8'd2 || rvy !== 8'd102) begin
      fails++;
      $display("FAIL write_read: got %0d/%0d/%0d/%0d expected 20/25/2/102", rpx, rpy, rvx, rvy);
    end
  endtask

  task automatic test_step();
    model_en = 1; lat = 3;
    pulse_step();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL step_busy: got %b expected 1", busy); end
    watch(60, 1);
    tests++;
    if (nbeg !== 4) begin fails++; $display("FAIL step_begin_count: got %0d expected 4", nbeg); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (beg_cyc[k] !== 5*k || beg_px[k] !== 8'(10*k)) begin
        fails++;
        $display("FAIL step_begin%0d: got cyc=%0d x=%0d expected cyc=%0d x=%0d", k, beg_cyc[k], beg_px[k], 5*k, 10*k);
      end
    end
    tests++;
    if (done_cyc !== 20 || busy !== 1'b0) begin
      fails++;
      $display("FAIL step_done: got cyc=%0d busy=%b expected cyc=20 busy=0", done_cyc, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL step_done_pulse: got %b expected 0", done); end
    inc_exp();
    for (int k = 0; k < N; k++) begin
      do_read(k);
      tests++;
      if (rpx !== 8'(10*k+1)) begin fails++; $display("FAIL step_readx%0d: got %0d expected %0d", k, rpx, 10*k+1); end
    end
    check_points("step_data");
  endtask

  task automatic test_timeout();
    model_en = 0;
    pulse_step();
    watch(60, 1);
    tests++;
    if (nbeg !== 4 || beg_cyc[1] !== 7 || beg_cyc[3] !== 21) begin
      fails++;
      $display("FAIL timeout_spacing: got n=%0d c1=%0d c3=%0d expected 4/7/21", nbeg, beg_cyc[1], beg_cyc[3]);
    end
    tests++;
    if (done_cyc !== 28) begin fails++; $display("FAIL timeout_done: got %0d expected 28", done_cyc); end
    tests++;
    if (to_cnt !== 8'd4) begin fails++; $display("FAIL timeout_count: got %0d expected 4", to_cnt); end
    check_points("timeout_data");
  endtask

  task automatic test_step_held();
    model_en = 1; lat = 3;
    step = 1'b1;
    @(negedge clk);
    release_at = 9;
    watch(60, 1);
    release_at = -1;
    tests++;
    if (nbeg !== 4 || done_cyc !== 20) begin
      fails++;
      $display("FAIL held_one_step: got n=%0d done=%0d expected 4/20", nbeg, done_cyc);
    end
    inc_exp();
    watch(10, 0);
    tests++;
    if (nbeg !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL held_not_queued: got n=%0d busy=%b expected 0/0", nbeg, busy);
    end
    step = 1'b1;
    @(negedge clk);
    watch(60, 1);
    inc_exp();
    @(negedge clk);
    step = 1'b0;
    tests++;
    if (busy !== 1'b1 || up_begin !== 1'b1) begin
      fails++;
      $display("FAIL held_restart: got busy=%b begin=%b expected 1/1", busy, up_begin);
    end
    watch(60, 1);
    tests++;
    if (nbeg !== 4 || done_cyc !== 20) begin
      fails++;
      $display("FAIL held_second_step: got n=%0d done=%0d expected 4/20", nbeg, done_cyc);
    end
    inc_exp();
    do_read(1);
    tests++;
    if (rpx !== 8'd14) begin fails++; $display("FAIL held_readx1: got %0d expected 14", rpx); end
    check_points("held_data");
  endtask

  task automatic test_write_busy();
    pulse_step();
    do_write(2, 8'd99, 8'd99, 8'd99, 8'd99);
    watch(60, 1);
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL busy_write_done: got %0d expected 1", done_cnt); end
    inc_exp();
    do_read(2);
    tests++;
    if (rpx !== 8'd25) begin fails++; $display("FAIL busy_write_x2: got %0d expected 25", rpx); end
    check_points("busy_write_data");
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    pulse_step();
    for (int n = 0; n < 40; n++) begin
      if (up_begin) cnt++;
      if (cnt == 3) break;
      @(negedge clk);
    end
    tests++;
    if (cnt !== 3) begin fails++; $display("FAIL rstmid_reach_pt2: got %0d expected 3", cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || up_begin !== 1'b0 || to_cnt !== 8'd0 || upx !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_state: got busy=%b done=%b begin=%b to=%0d upx=%0d expected 0", busy, done, up_begin, to_cnt, upx);
    end
    watch(12, 0);
    tests++;
    if (done_cnt !== 0 || nbeg !== 0) begin
      fails++;
      $display("FAIL rstmid_quiet: got done=%0d begins=%0d expected 0/0", done_cnt, nbeg);
    end
    for (int i = 0; i < N; i++) begin
      exp_px[i] = 8'd0; exp_py[i] = 8'd0; exp_vx[i] = 8'd0; exp_vy[i] = 8'd0;
    end
    check_points("rstmid_data");
  endtask

  task automatic test_coincident();
    model_en = 1; lat = TO;
    pulse_step();
    watch(80, 1);
    tests++;
    if (done_cyc !== 28) begin fails++; $display("FAIL coinc_done: got %0d expected 28", done_cyc); end
    tests++;
    if (to_cnt !== 8'd0) begin fails++; $display("FAIL coinc_count: got %0d expected 0", to_cnt); end
    inc_exp();
    do_read(3);
    tests++;
    if (rpx !== 8'd1 || rvy !== 8'd3) begin
      fails++;
      $display("FAIL coinc_read3: got %0d/%0d expected 1/3", rpx, rvy);
    end
    check_points("coinc_data");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_step();
    test_timeout();
    test_step_held();
    test_write_busy();
    test_reset_mid();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
